// File: rtl/bin2bcd_seq_ctrl_if.sv
// ============================================================================
// Module  : bin2bcd_seq_ctrl_if
// Brief   : start/busy/done handshake bundle between a binary producer and
//           the sequential binary-to-BCD converter (ovf lane: BIN2BCD_OVF_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface bin2bcd_seq_ctrl_if #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
`ifdef BIN2BCD_OVF_EN
  logic                  ovf;
`endif

  modport master (
    output start, bin_in,
`ifdef BIN2BCD_OVF_EN
    input  ovf,
`endif
    input  busy, done, bcd_out
  );

  modport slave (
    input  start, bin_in,
`ifdef BIN2BCD_OVF_EN
    output ovf,
`endif
    output busy, done, bcd_out
  );
endinterface

`default_nettype wire

// File: rtl/bin2bcd_seq_ctrl.sv
// ============================================================================
// Module  : bin2bcd_seq_ctrl
// Brief   : Multi-cycle double-dabble converter, one shift per clock, using
//           DIGITS add-3 cells. Optional overflow flag: BIN2BCD_OVF_EN.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module adder3 (
  input  wire logic [3:0] din,
  output logic      [3:0] dout
);
  // 10-15 never occur in a correct conversion; forced to 0 for determinism.
  always_comb begin
    dout = 4'd0;
    if (din <= 4'd4)      dout = din;
    else if (din <= 4'd9) dout = din + 4'd3;
  end
endmodule

module bin2bcd_seq_ctrl #(
  parameter int BIN_W  = 8,
  parameter int DIGITS = 3
) (
  input wire logic          clk,
  input wire logic          rst_n,
  bin2bcd_seq_ctrl_if.slave bus
);
  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t             r_state;
  logic [BIN_W-1:0]   r_bin;
  logic [BCD_W-1:0]   r_bcd;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_busy;
  logic               r_done;
  logic [BCD_W-1:0]   r_bcd_out;
  logic [BCD_W-1:0]   w_corr;
  logic [BCD_W-1:0]   w_bcd_shift;
  logic [BIN_W-1:0]   w_bin_shift;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      adder3 u_add3 (
        .din  (r_bcd[4*g +: 4]),
        .dout (w_corr[4*g +: 4])
      );
    end
  endgenerate

  // The bit leaving the top digit falls off the left end of the shift.
  assign w_bcd_shift = (w_corr << 1) | {{(BCD_W-1){1'b0}}, r_bin[BIN_W-1]};
  assign w_bin_shift = r_bin << 1;

`ifdef BIN2BCD_OVF_EN
  logic r_ovf_work;
  logic r_ovf;
  logic w_ovf_next;

  assign w_ovf_next = r_ovf_work | w_corr[BCD_W-1];
  assign bus.ovf    = r_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf_work <= 1'b0;
      r_ovf      <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.start) r_ovf_work <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_ovf_work <= w_ovf_next;
      if (r_cnt == CNT_W'(1)) r_ovf <= w_ovf_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_bin     <= '0;
      r_bcd     <= '0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_bcd_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_bin   <= bus.bin_in;
            r_bcd   <= '0;
            r_cnt   <= CNT_W'(BIN_W);
            r_busy  <= 1'b1;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          r_bin <= w_bin_shift;
          r_bcd <= w_bcd_shift;
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_bcd_out <= w_bcd_shift;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
            r_state   <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.bcd_out = r_bcd_out;

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq_ctrl.sv
// ============================================================================
// Module  : tb_bin2bcd_seq_ctrl
// Brief   : Directed bench for bin2bcd_seq_ctrl; DIGITS=2 overflow vectors
//           are used when BIN2BCD_OVF_EN is defined.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_bin2bcd_seq_ctrl;
  localparam int BIN_W = 8;
`ifdef BIN2BCD_OVF_EN
  localparam int DIGITS = 2;
`else
  localparam int DIGITS = 3;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq_ctrl_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq_ctrl #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode 0: plain; 1: start re-pulsed with bin_in=7 through busy and done;
  // mode 2: bin_in scrambled every cycle after the accepted start.
  task automatic conv(input logic [BIN_W-1:0] v, input logic [31:0] exp,
                      input logic exp_ovf, input int mode);
    bus.bin_in = v;
    bus.start  = 1'b1;
    tick();
    if (mode == 1) bus.bin_in = 8'd7;
    else           bus.start  = 1'b0;
    for (int i = 0; i < BIN_W; i++) begin
      chk($sformatf("busy_c%0d", i), 32'(bus.busy), 32'd1);
      chk($sformatf("nodone_c%0d", i), 32'(bus.done), 32'd0);
      if (mode == 2) bus.bin_in = BIN_W'($urandom);
      tick();
    end
    chk("done_pulse", 32'(bus.done), 32'd1);
    chk("busy_at_done", 32'(bus.busy), 32'd0);
    chk($sformatf("bcd_of_%0d", v), 32'(bus.bcd_out), exp);
`ifdef BIN2BCD_OVF_EN
    chk($sformatf("ovf_of_%0d", v), 32'(bus.ovf), 32'(exp_ovf));
`else
    chk("ovf_unused", 32'(exp_ovf), 32'd0 | 32'(exp_ovf & bus.done));
`endif
    tick();
    bus.start = 1'b0;
    chk("done_one_cycle", 32'(bus.done), 32'd0);
    chk("idle_after_done", 32'(bus.busy), 32'd0);
    chk("bcd_held", 32'(bus.bcd_out), exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd", 32'(bus.bcd_out), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_no_start", 32'(bus.busy), 32'd0);

`ifdef BIN2BCD_OVF_EN
    conv(8'd255, 32'h55, 1'b1, 0);
    conv(8'd100, 32'h00, 1'b1, 0);
    conv(8'd99,  32'h99, 1'b0, 0);
    conv(8'd0,   32'h00, 1'b0, 0);
`else
    conv(8'd0,   32'h000, 1'b0, 0);
    // Back-to-back: each conv leaves the next start sampled 10 edges later.
    conv(8'd255, 32'h255, 1'b0, 0);
    conv(8'd99,  32'h099, 1'b0, 0);
    conv(8'd128, 32'h128, 1'b0, 0);
    conv(8'd200, 32'h200, 1'b0, 1);
    tick();
    chk("ignored_start_idle", 32'(bus.busy), 32'd0);
    conv(8'd64,  32'h064, 1'b0, 2);

    // Abort in the 4th SHIFT cycle.
    bus.bin_in = 8'd173;
    bus.start  = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (3) tick();
    chk("busy_before_abort", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_bcd", 32'(bus.bcd_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort_no_done", 32'(bus.done), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < BIN_W + 2; i++) begin
      chk("post_abort_idle", 32'(bus.busy | bus.done), 32'd0);
      tick();
    end
    conv(8'd42, 32'h042, 1'b0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
